// File: rtl/preamble_peak_detector.sv
`default_nettype none
// ============================================================================
// Module   : preamble_peak_detector
// Purpose  : After a threshold crossing, finds the correlation peak inside a
//            fixed window, strobes frame start, then blanks for a hold-off.
// Revision : 1.0 - initial release
// ============================================================================
module preamble_peak_detector #(
    parameter int DATA_SIZE = 16,
    parameter int PEAK_WIN  = 32,
    parameter int HOLDOFF   = 64,
    parameter int CNT_SIZE  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [DATA_SIZE-1:0]          in_corr,
    input  logic [DATA_SIZE-1:0]          in_porog,
    output logic                          out_detect,
    output logic [DATA_SIZE-1:0]          out_peak,
    output logic [$clog2(PEAK_WIN)-1:0]   out_delay,
    output logic                          out_busy,
    output logic [CNT_SIZE-1:0]           out_det_count
);

    localparam int WW = $clog2(PEAK_WIN);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [WW-1:0] c_win_last  = WW'(PEAK_WIN - 1);
    localparam logic [HW-1:0] c_hold_last = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_SIZE-1:0]  r_peak;
    logic [WW-1:0]         r_pos;
    logic [WW-1:0]         r_win;
    logic [HW-1:0]         r_hold;

    state_t                w_state_nxt;
    logic [DATA_SIZE-1:0]  w_peak_nxt;
    logic [WW-1:0]         w_pos_nxt;
    logic [WW-1:0]         w_win_nxt;
    logic [HW-1:0]         w_hold_nxt;
    logic                  w_detect_nxt;
    logic [DATA_SIZE-1:0]  w_out_peak_nxt;
    logic [WW-1:0]         w_out_delay_nxt;
    logic [CNT_SIZE-1:0]   w_count_nxt;
    logic [DATA_SIZE-1:0]  w_cand_peak;
    logic [WW-1:0]         w_cand_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_peak        <= '0;
            r_pos         <= '0;
            r_win         <= '0;
            r_hold        <= '0;
            out_detect    <= 1'b0;
            out_peak      <= '0;
            out_delay     <= '0;
            out_busy      <= 1'b0;
            out_det_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_peak        <= w_peak_nxt;
            r_pos         <= w_pos_nxt;
            r_win         <= w_win_nxt;
            r_hold        <= w_hold_nxt;
            out_detect    <= w_detect_nxt;
            out_peak      <= w_out_peak_nxt;
            out_delay     <= w_out_delay_nxt;
            out_busy      <= (w_state_nxt != S_IDLE);
            out_det_count <= w_count_nxt;
        end
    end

    // Strict '>' keeps the earliest of equal peaks.
    always_comb begin
        w_cand_peak = (in_corr > r_peak) ? in_corr : r_peak;
        w_cand_pos  = (in_corr > r_peak) ? r_win   : r_pos;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_peak_nxt      = r_peak;
        w_pos_nxt       = r_pos;
        w_win_nxt       = r_win;
        w_hold_nxt      = r_hold;
        w_detect_nxt    = 1'b0;
        w_out_peak_nxt  = out_peak;
        w_out_delay_nxt = out_delay;
        w_count_nxt     = out_det_count;
        if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (in_corr > in_porog) begin
                        w_state_nxt = S_SEARCH;
                        w_peak_nxt  = in_corr;
                        w_pos_nxt   = '0;
                        w_win_nxt   = WW'(1);
                    end
                end
                S_SEARCH: begin
                    w_peak_nxt = w_cand_peak;
                    w_pos_nxt  = w_cand_pos;
                    if (r_win == c_win_last) begin
                        w_detect_nxt    = 1'b1;
                        w_out_peak_nxt  = w_cand_peak;
                        w_out_delay_nxt = c_win_last - w_cand_pos;
                        w_count_nxt     = out_det_count + 1'b1;
                        w_hold_nxt      = '0;
                        w_state_nxt     = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
                    end else begin
                        w_win_nxt = r_win + 1'b1;
                    end
                end
                S_HOLD: begin
                    w_hold_nxt = r_hold + 1'b1;
                    if (r_hold == c_hold_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
